// File: rtl/u_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package u_ifu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int PC_INC   = 4;

  // One fetch queue entry: the instruction word tagged with its PC.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] ins;
  } fetch_ent_t;

endpackage

// File: rtl/u_ifu_fq_if.sv
// Fetch unit bus: instruction SRAM port, redirect request and decode handshake.
interface u_ifu_fq_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] ins_a;
  logic              ins_e;
  logic [XLEN-1:0]   ins;
  logic              redir_vld;
  logic [XLEN-1:0]   redir_pc;
  logic              ifu_vld;
  logic              ifu_rdy;
  logic [XLEN-1:0]   ifu_pc;
  logic [XLEN-1:0]   ifu_ins;

  modport master (
    output ins_a, ins_e, ifu_vld, ifu_pc, ifu_ins,
    input  ins, redir_vld, redir_pc, ifu_rdy
  );

  modport slave (
    input  ins_a, ins_e, ifu_vld, ifu_pc, ifu_ins,
    output ins, redir_vld, redir_pc, ifu_rdy
  );

endinterface

// File: rtl/u_ifu_fifo.sv
// Registered synchronous FIFO for fetch entries; clr overrides push/pop.
module u_ifu_fifo
  import u_ifu_pkg::*;
#(
  parameter  int  DEPTH = 4,
  parameter  type ent_t = fetch_ent_t,
  localparam int  PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           push,
  input  logic           pop,
  input  logic           clr,
  input  ent_t           din,
  output ent_t           head,
  output logic [PTR_W:0] count,
  output logic           empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push & ((count != FULL_CNT) | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is reset too, so the head (and thus the fetch outputs) reads zero after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/u_ifu_fq.sv
// Instruction fetch unit with fetch queue and PC redirect/flush.
// Optional performance counters are built when IFU_PERF_EN is defined.
module u_ifu_fq
  import u_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  u_ifu_fq_if.master      bus
`ifdef IFU_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch,
  output logic [XLEN-1:0] perf_stall,
  output logic [XLEN-1:0] perf_flush
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } ent_t;

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  INC     = XLEN'(PC_INC);
  localparam logic [XLEN-1:0]  ALIGN   = ~XLEN'(3);

  logic [XLEN-1:0]  pc_q, inf_pc_q, redir_tgt;
  logic             inf_vld_q, redir, pop, issue;
  logic [CNT_W-1:0] count, occ;
  logic             empty;
  ent_t             head, din;

  assign redir     = bus.redir_vld;
  assign redir_tgt = bus.redir_pc & ALIGN;
  assign pop       = ~empty & bus.ifu_rdy;

  // Queued + in-flight entries after this cycle's pop; issuing only below DEPTH
  // guarantees every returned word has a queue slot.
  assign occ   = count + CNT_W'(inf_vld_q) - CNT_W'(pop);
  assign issue = redir | (occ < DEPTH_C);

  assign bus.ins_e = rstn & issue;
  assign bus.ins_a = (rstn & redir) ? redir_tgt[ADDR_W-1:0] : pc_q[ADDR_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q      <= RESET_PC;
      inf_vld_q <= 1'b0;
      inf_pc_q  <= '0;
    end else begin
      inf_vld_q <= issue;
      if (redir) begin
        pc_q     <= redir_tgt + INC;
        inf_pc_q <= redir_tgt;
      end else if (issue) begin
        pc_q     <= pc_q + INC;
        inf_pc_q <= pc_q;
      end
    end
  end

  // The response to a fetch issued before a redirect is dropped instead of queued.
  assign din = '{pc: inf_pc_q, ins: bus.ins};

  u_ifu_fifo #(
    .DEPTH (DEPTH),
    .ent_t (ent_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inf_vld_q & ~redir),
    .pop   (pop),
    .clr   (redir),
    .din   (din),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign bus.ifu_vld = ~empty;
  assign bus.ifu_pc  = head.pc;
  assign bus.ifu_ins = head.ins;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (pop & ~redir)           perf_fetch <= perf_fetch + 1'b1;
      if (~empty & ~bus.ifu_rdy)  perf_stall <= perf_stall + 1'b1;
      if (redir)                  perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule
